// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes, pbus FSM states,
// peripheral register offsets and the load lane-rotate/extend function.
package data_ram_pkg;

    typedef enum logic [1:0] {BYTE, HALF, WORD} acc_size_e;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} pbus_state_e;

    localparam logic [1:0] PBUS_OFS_ADDR  = 2'd0;
    localparam logic [1:0] PBUS_OFS_WDATA = 2'd1;
    localparam logic [1:0] PBUS_OFS_RDATA = 2'd2;

    // Rotate the four bank bytes so the first accessed byte lands in bits [7:0], then extend.
    function automatic logic [31:0] extendLoad(input logic [31:0] lanes, input logic [1:0] ofs,
                                               input acc_size_e size, input logic sgn);
        logic [31:0] rot;
        logic [1:0]  lane;
        for (int k = 0; k < 4; k++) begin
            lane = 2'(int'(ofs) + k);
            rot[8*k +: 8] = lanes[8*lane +: 8];
        end
        case (size)
            BYTE:    return {{24{sgn & rot[7]}}, rot[7:0]};
            HALF:    return {{16{sgn & rot[15]}}, rot[15:0]};
            default: return rot;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_ctrl_gen_byte_bank.sv
// One byte lane of the data RAM: single-port 8-bit synchronous RAM with registered read data.
module byte_bank #(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/data_ram_ctrl_gen.sv
// Data-memory controller between l2 and l3: four byte banks for single-cycle misaligned access,
// plus memory-mapped pbus registers with a req/ack handshake. Optional macro: PBUS_TIMEOUT_EN.
module data_ram_ctrl_gen
    import data_ram_pkg::*;
#(
    parameter int RAM_BYTES    = 2048,
    parameter int PBUS_BASE    = 65536,
    parameter int PBUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear_l3,
    input  logic [31:0] alu_q_l2,
    input  logic [31:0] xrs2_l2,
    input  logic        ins_lb_l2,
    input  logic        ins_lh_l2,
    input  logic        ins_lw_l2,
    input  logic        ins_lbu_l2,
    input  logic        ins_lhu_l2,
    input  logic        ins_sb_l2,
    input  logic        ins_sh_l2,
    input  logic        ins_sw_l2,
    input  logic [31:0] pbus_rdata,
    input  logic        pbus_ack,
    output logic [31:0] ram_rdata_l3,
    output logic        acc_err_l3,
    output logic [31:0] pbus_addr,
    output logic [31:0] pbus_wdata,
    output logic        pbus_req,
    output logic        pbus_we,
    output logic        stall
);

    localparam int DEPTH = RAM_BYTES / 4;
    localparam int BAW   = $clog2(DEPTH);

    logic        isLoad, isStore, isAcc, loadSigned, inRam;
    logic        hitAddr, hitWdata, hitRdata, pbusAcc, accErr, launchWr, launchRd, timeout;
    acc_size_e   accSize;
    logic [1:0]  extra;
    logic [32:0] lastByte;
    logic [3:0]  laneWe;
    logic [1:0]  laneOfs   [4];
    logic [BAW-1:0] laneAddr [4];
    logic [7:0]  laneWdata [4];
    logic [31:0] bankData;

    pbus_state_e state_q;
    logic        pbusReq_q, pbusWe_q;
    logic [31:0] pbusAddr_q, pbusWdata_q, data_q;
    logic        selRam_q, sgn_q, err_q;
    logic [1:0]  ofs_q;
    acc_size_e   size_q;

    always_comb begin
        isLoad     = ins_lb_l2 | ins_lh_l2 | ins_lw_l2 | ins_lbu_l2 | ins_lhu_l2;
        isStore    = ins_sb_l2 | ins_sh_l2 | ins_sw_l2;
        isAcc      = isLoad | isStore;
        loadSigned = ins_lb_l2 | ins_lh_l2;
        accSize    = BYTE;
        extra      = 2'd0;
        if (ins_lh_l2 | ins_lhu_l2 | ins_sh_l2) begin
            accSize = HALF;
            extra   = 2'd1;
        end
        if (ins_lw_l2 | ins_sw_l2) begin
            accSize = WORD;
            extra   = 2'd3;
        end
        lastByte = {1'b0, alu_q_l2} + {31'd0, extra};
        inRam    = lastByte < 33'(RAM_BYTES);
        hitAddr  = alu_q_l2 == 32'(PBUS_BASE) + 32'(PBUS_OFS_ADDR);
        hitWdata = alu_q_l2 == 32'(PBUS_BASE) + 32'(PBUS_OFS_WDATA);
        hitRdata = alu_q_l2 == 32'(PBUS_BASE) + 32'(PBUS_OFS_RDATA);
        pbusAcc  = isAcc && !inRam && accSize == WORD && (hitAddr || hitWdata || (hitRdata && isLoad));
        accErr   = isAcc && !inRam && !pbusAcc;
        launchWr = pbusAcc && isStore && hitWdata;
        launchRd = pbusAcc && isLoad && hitRdata;
    end

    // Lane i serves byte k = (i - addr[1:0]) mod 4; lanes below the start offset wrap to the next word.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            laneOfs[i]   = 2'(i - int'(alu_q_l2[1:0]));
            laneAddr[i]  = alu_q_l2[BAW+1:2] + BAW'(i < int'(alu_q_l2[1:0]));
            laneWe[i]    = isStore && inRam && (laneOfs[i] <= extra);
            laneWdata[i] = xrs2_l2[8*laneOfs[i] +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gBank
        byte_bank #(.DEPTH(DEPTH)) uBank (
            .clk     (clk),
            .we_i    (laneWe[g]),
            .addr_i  (laneAddr[g]),
            .wdata_i (laneWdata[g]),
            .rdata_o (bankData[8*g +: 8])
        );
    end

`ifdef PBUS_TIMEOUT_EN
    localparam int CW = $clog2(PBUS_TIMEOUT + 1);
    logic [CW-1:0] waitCnt_q;

    assign timeout = (state_q != IDLE) && !pbus_ack && (waitCnt_q == CW'(PBUS_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn || state_q == IDLE) waitCnt_q <= '0;
        else if (!pbus_ack)           waitCnt_q <= waitCnt_q + CW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    assign stall = (state_q == IDLE) ? (launchWr || launchRd) : !(pbus_ack || timeout);

    // Register writes are gated to IDLE so the held l2 instruction cannot touch them while waiting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pbusReq_q   <= 1'b0;
            pbusWe_q    <= 1'b0;
            pbusAddr_q  <= '0;
            pbusWdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pbusAcc && isStore && hitAddr)  pbusAddr_q  <= xrs2_l2;
                    if (pbusAcc && isStore && hitWdata) pbusWdata_q <= xrs2_l2;
                    if (launchWr) begin
                        state_q   <= WR_WAIT;
                        pbusReq_q <= 1'b1;
                        pbusWe_q  <= 1'b1;
                    end else if (launchRd) begin
                        state_q   <= RD_WAIT;
                        pbusReq_q <= 1'b1;
                        pbusWe_q  <= 1'b0;
                    end
                end
                default: begin
                    if (pbus_ack || timeout) begin
                        state_q   <= IDLE;
                        pbusReq_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear_l3) begin
            selRam_q <= 1'b0;
            ofs_q    <= 2'd0;
            size_q   <= BYTE;
            sgn_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else if (state_q == IDLE) begin
            selRam_q <= isLoad && inRam;
            ofs_q    <= alu_q_l2[1:0];
            size_q   <= accSize;
            sgn_q    <= loadSigned;
            err_q    <= accErr;
            if (pbusAcc && isLoad && hitAddr)       data_q <= pbusAddr_q;
            else if (pbusAcc && isLoad && hitWdata) data_q <= pbusWdata_q;
            else                                    data_q <= '0;
        end else begin
            selRam_q <= 1'b0;
            err_q    <= timeout;
            data_q   <= (state_q == RD_WAIT && pbus_ack) ? pbus_rdata : 32'd0;
        end
    end

    assign ram_rdata_l3 = selRam_q ? extendLoad(bankData, ofs_q, size_q, sgn_q) : data_q;
    assign acc_err_l3   = err_q;
    assign pbus_addr    = pbusAddr_q;
    assign pbus_wdata   = pbusWdata_q;
    assign pbus_req     = pbusReq_q;
    assign pbus_we      = pbusWe_q;

endmodule

// File: tb/tb_data_ram_ctrl_gen.sv
// Scoreboard bench for data_ram_ctrl_gen; the timeout section runs only when PBUS_TIMEOUT_EN is defined.
module tb_data_ram_ctrl_gen;

    localparam int RAM_BYTES    = 2048;
    localparam int PBUS_BASE    = 65536;
    localparam int PBUS_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstn, clear_l3;
    logic [31:0] alu_q_l2, xrs2_l2, pbus_rdata;
    logic        ins_lb_l2, ins_lh_l2, ins_lw_l2, ins_lbu_l2, ins_lhu_l2;
    logic        ins_sb_l2, ins_sh_l2, ins_sw_l2, pbus_ack;
    logic [31:0] ram_rdata_l3, pbus_addr, pbus_wdata;
    logic        acc_err_l3, pbus_req, pbus_we, stall;

    typedef enum int {K_NONE, K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW} kind_e;
    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   stallCnt, reqCnt;

    data_ram_ctrl_gen #(
        .RAM_BYTES(RAM_BYTES), .PBUS_BASE(PBUS_BASE), .PBUS_TIMEOUT(PBUS_TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .clear_l3(clear_l3), .alu_q_l2(alu_q_l2), .xrs2_l2(xrs2_l2),
        .ins_lb_l2(ins_lb_l2), .ins_lh_l2(ins_lh_l2), .ins_lw_l2(ins_lw_l2),
        .ins_lbu_l2(ins_lbu_l2), .ins_lhu_l2(ins_lhu_l2), .ins_sb_l2(ins_sb_l2),
        .ins_sh_l2(ins_sh_l2), .ins_sw_l2(ins_sw_l2), .pbus_rdata(pbus_rdata),
        .pbus_ack(pbus_ack), .ram_rdata_l3(ram_rdata_l3), .acc_err_l3(acc_err_l3),
        .pbus_addr(pbus_addr), .pbus_wdata(pbus_wdata), .pbus_req(pbus_req),
        .pbus_we(pbus_we), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setIns(input kind_e k);
        ins_lb_l2  = (k == K_LB);
        ins_lh_l2  = (k == K_LH);
        ins_lw_l2  = (k == K_LW);
        ins_lbu_l2 = (k == K_LBU);
        ins_lhu_l2 = (k == K_LHU);
        ins_sb_l2  = (k == K_SB);
        ins_sh_l2  = (k == K_SH);
        ins_sw_l2  = (k == K_SW);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbQ.pop_front();
            check({e.tag, "_data"}, ram_rdata_l3, e.data);
            check({e.tag, "_err"}, {31'd0, acc_err_l3}, {31'd0, e.err});
        end
    endtask

    // One non-stalling access: drive in one cycle, compare l3 outputs one cycle later.
    task automatic applyStimulus(input string tag, input kind_e k, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input logic expErr);
        @(negedge clk);
        alu_q_l2 = addr;
        xrs2_l2  = wdata;
        setIns(k);
        sbQ.push_back('{tag, expData, expErr});
        #1;
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        setIns(K_NONE);
        checkOutput();
    endtask

    initial begin
        rstn = 1'b0; clear_l3 = 1'b0; alu_q_l2 = '0; xrs2_l2 = '0;
        pbus_rdata = '0; pbus_ack = 1'b0;
        setIns(K_NONE);
        repeat (2) @(negedge clk);
        check("rst_rdata", ram_rdata_l3, 32'd0);
        check("rst_err", {31'd0, acc_err_l3}, 32'd0);
        check("rst_paddr", pbus_addr, 32'd0);
        check("rst_pwdata", pbus_wdata, 32'd0);
        check("rst_req", {31'd0, pbus_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rstn = 1'b1;

        applyStimulus("sw100", K_SW, 32'h100, 32'h11223344, 32'h0, 1'b0);
        applyStimulus("lw100", K_LW, 32'h100, 32'h0, 32'h11223344, 1'b0);
        applyStimulus("lb100", K_LB, 32'h100, 32'h0, 32'h00000044, 1'b0);
        applyStimulus("lb103", K_LB, 32'h103, 32'h0, 32'h00000011, 1'b0);
        applyStimulus("sw101", K_SW, 32'h101, 32'hA1B2C3D4, 32'h0, 1'b0);
        applyStimulus("lw101", K_LW, 32'h101, 32'h0, 32'hA1B2C3D4, 1'b0);
        applyStimulus("lh103", K_LH, 32'h103, 32'h0, 32'hFFFFA1B2, 1'b0);
        applyStimulus("lhu103", K_LHU, 32'h103, 32'h0, 32'h0000A1B2, 1'b0);
        applyStimulus("lb100b", K_LB, 32'h100, 32'h0, 32'h00000044, 1'b0);
        applyStimulus("lw7fe", K_LW, 32'h7FE, 32'h0, 32'h0, 1'b1);
        applyStimulus("sb900", K_SB, 32'h900, 32'h55, 32'h0, 1'b1);
        applyStimulus("lb100c", K_LB, 32'h100, 32'h0, 32'h00000044, 1'b0);
        applyStimulus("sh7fe", K_SH, 32'h7FE, 32'h0000BEEF, 32'h0, 1'b0);
        applyStimulus("lhu7fe", K_LHU, 32'h7FE, 32'h0, 32'h0000BEEF, 1'b0);
        applyStimulus("lb7ff", K_LB, 32'h7FF, 32'h0, 32'hFFFFFFBE, 1'b0);
        clear_l3 = 1'b1;
        applyStimulus("lwClear", K_LW, 32'h100, 32'h0, 32'h0, 1'b0);
        clear_l3 = 1'b0;

        applyStimulus("swPaddr", K_SW, PBUS_BASE, 32'h40, 32'h0, 1'b0);
        check("paddrReg", pbus_addr, 32'h40);
        applyStimulus("lbPaddr", K_LB, PBUS_BASE, 32'h0, 32'h0, 1'b1);
        applyStimulus("swPrdata", K_SW, PBUS_BASE + 2, 32'h1, 32'h0, 1'b1);
        applyStimulus("lwPaddr", K_LW, PBUS_BASE, 32'h0, 32'h40, 1'b0);

        // Write transaction: ack arrives after three wait cycles without it.
        @(negedge clk);
        alu_q_l2 = PBUS_BASE + 1;
        xrs2_l2  = 32'hDEAD;
        setIns(K_SW);
        stallCnt = 0;
        reqCnt   = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) setIns(K_NONE);
            pbus_ack = (c == 4);
            #1;
            if (stall) stallCnt++;
            if (pbus_req) begin
                reqCnt++;
                check("wrWe", {31'd0, pbus_we}, 32'd1);
                check("wrAddr", pbus_addr, 32'h40);
                check("wrData", pbus_wdata, 32'hDEAD);
            end
        end
        pbus_ack = 1'b0;
        check("wrStallCycles", 32'(stallCnt), 32'd4);
        check("wrReqCycles", 32'(reqCnt), 32'd4);
        check("wrRdata", ram_rdata_l3, 32'd0);

        // Read transaction acked in the second wait cycle.
        @(negedge clk);
        alu_q_l2   = PBUS_BASE + 2;
        pbus_rdata = 32'hCAFEF00D;
        setIns(K_LW);
        #1;
        check("rdStall0", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("rdStall1", {31'd0, stall}, 32'd1);
        check("rdReq", {31'd0, pbus_req}, 32'd1);
        check("rdWe", {31'd0, pbus_we}, 32'd0);
        @(negedge clk);
        pbus_ack = 1'b1;
        #1;
        check("rdStallAck", {31'd0, stall}, 32'd0);
        sbQ.push_back('{"rdData", 32'hCAFEF00D, 1'b0});
        @(negedge clk);
        pbus_ack = 1'b0;
        setIns(K_NONE);
        #1;
        checkOutput();
        check("rdReqDrop", {31'd0, pbus_req}, 32'd0);

        // Reset while waiting for a read aborts the transaction.
        @(negedge clk);
        alu_q_l2 = PBUS_BASE + 2;
        setIns(K_LW);
        @(negedge clk);
        #1;
        check("rstWaitReq", {31'd0, pbus_req}, 32'd1);
        rstn = 1'b0;
        setIns(K_NONE);
        @(negedge clk);
        #1;
        check("rstAbortReq", {31'd0, pbus_req}, 32'd0);
        check("rstAbortStall", {31'd0, stall}, 32'd0);
        check("rstAbortPaddr", pbus_addr, 32'd0);
        rstn = 1'b1;

        // Ack while idle is ignored.
        @(negedge clk);
        pbus_ack = 1'b1;
        #1;
        check("idleAckStall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        pbus_ack = 1'b0;
        #1;
        check("idleAckReq", {31'd0, pbus_req}, 32'd0);

`ifdef PBUS_TIMEOUT_EN
        // No ack: the fourth wait cycle times out with stall low.
        @(negedge clk);
        alu_q_l2   = PBUS_BASE + 2;
        pbus_rdata = 32'h12345678;
        setIns(K_LW);
        stallCnt = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) setIns(K_NONE);
            #1;
            if (stall) stallCnt++;
            if (c == 4) sbQ.push_back('{"toData", 32'h0, 1'b1});
            if (c == 5) checkOutput();
        end
        check("toStallCycles", 32'(stallCnt), 32'd4);
        check("toReq", {31'd0, pbus_req}, 32'd0);
`endif

        check("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
